// File: rtl/hs4ph_pkg.sv
//------------------------------------------------------------------------------
// Module      : hs4ph_pkg
// Description : Shared types and constants for the 4-phase handshake slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hs4ph_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } hs_state_t;

    localparam int c_sync_stages_min = 2;
    localparam int c_sync_stages_max = 4;

endpackage : hs4ph_pkg

`default_nettype wire

// File: rtl/sync_ff.sv
//------------------------------------------------------------------------------
// Module      : sync_ff
// Description : N-stage reset-to-0 single-bit synchronizer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : sync_ff

`default_nettype wire

// File: rtl/sync_slave_4ph.sv
//------------------------------------------------------------------------------
// Module      : sync_slave_4ph
// Description : Clocked consumer of a 4-phase req/ack channel with handshake
//               counter and sticky protocol-error flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_slave_4ph
    import hs4ph_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             r,
    output logic             a,
    output logic             start_o,
    input  logic             done_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic             err_o
);

    if (SYNC_STAGES < c_sync_stages_min || SYNC_STAGES > c_sync_stages_max) begin : g_bad_sync_stages
        $error("sync_slave_4ph: SYNC_STAGES out of range");
    end

    logic             w_r_s;
    hs_state_t        r_state;
    hs_state_t        w_next;
    logic             w_err_set;
    logic             r_a;
    logic             r_start;
    logic             r_busy;
    logic             r_err;
    logic [CNT_W-1:0] r_count;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (r),
        .q    (w_r_s)
    );

    // Errors never abort the handshake; they are only recorded.
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (done_i) w_err_set = 1'b1;
                if (w_r_s)  w_next    = START;
            end
            START: begin
                if (!w_r_s) w_err_set = 1'b1;
                w_next = done_i ? ACK : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!w_r_s) w_err_set = 1'b1;
                if (done_i) w_next    = ACK;
            end
            ACK: begin
                if (done_i) w_err_set = 1'b1;
                if (!w_r_s) w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each comes straight off a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_a     <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_a     <= (w_next == ACK);
            r_start <= (w_next == START);
            r_busy  <= (w_next != IDLE);
            r_err   <= r_err | w_err_set;
            if (r_state == ACK && w_next == IDLE) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign a       = r_a;
    assign start_o = r_start;
    assign busy_o  = r_busy;
    assign err_o   = r_err;
    assign count_o = r_count;

endmodule : sync_slave_4ph

`default_nettype wire

// File: tb/tb_sync_slave_4ph.sv
//------------------------------------------------------------------------------
// Module      : tb_sync_slave_4ph
// Description : Self-checking directed bench for sync_slave_4ph (SYNC_STAGES=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_slave_4ph;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rstn;
    logic             r;
    logic             a;
    logic             start_o;
    logic             done_i;
    logic             busy_o;
    logic [CNT_W-1:0] count_o;
    logic             err_o;

    int total;
    int bad;
    int viol;
    logic busy_prev;

    typedef struct {
        logic        r;
        logic        d;
        logic        a;
        logic        start;
        logic        busy;
        logic        err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [10];

    sync_slave_4ph #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .r       (r),
        .a       (a),
        .start_o (start_o),
        .done_i  (done_i),
        .busy_o  (busy_o),
        .count_o (count_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // start_o must only ever appear when busy_o was low the cycle before.
    initial begin
        busy_prev = 1'b0;
        viol      = 0;
    end
    always @(negedge clk) begin
        if (start_o && busy_prev) viol++;
        busy_prev = busy_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return start_o;
            default: return a;
        endcase
    endfunction

    task automatic wait_lvl(input int sel, input logic val, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (sig(sel) === val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: timeout waiting for level %0b", nm, val);
        end
    endtask

    // Requester plus local service: done_i is raised for one cycle, dly
    // cycles after start_o is seen (0 = inside the START cycle).
    task automatic handshake(input int dly, input int hold, input bit finish);
        @(negedge clk);
        r = 1'b1;
        wait_lvl(0, 1'b1, "wait_start");
        repeat (dly) @(negedge clk);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        wait_lvl(1, 1'b1, "wait_a_rise");
        repeat (hold) @(negedge clk);
        if (finish) begin
            r = 1'b0;
            wait_lvl(1, 1'b0, "wait_a_fall");
        end
    endtask

    initial begin
        bit   ok;
        total  = 0;
        bad    = 0;
        r      = 1'b0;
        done_i = 1'b0;
        rstn   = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};

        // Reset, checked while held low.
        #1 rstn = 1'b0;
        #5;
        chk("rst_a", a, 0);
        chk("rst_start", start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_count", count_o, 0);
        #1 rstn = 1'b1;

        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (a || start_o || busy_o || err_o || count_o != 0) ok = 1'b0;
        end
        chk("idle_quiet", ok, 1);

        // Single handshake then start of a second one, edge by edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            r      = vecs[i].r;
            done_i = vecs[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_a", i), a, vecs[i].a);
            chk($sformatf("vec%0d_start", i), start_o, vecs[i].start);
            chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].busy);
            chk($sformatf("vec%0d_err", i), err_o, vecs[i].err);
            chk($sformatf("vec%0d_cnt", i), count_o, vecs[i].cnt);
        end

        // Delayed service: done_i raised 10 cycles after start_o.
        ok = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            done_i = 1'b0;
            @(posedge clk);
            #1;
            if (!busy_o || a || start_o) ok = 1'b0;
        end
        chk("delay_wait_busy", ok, 1);
        @(negedge clk);
        done_i = 1'b1;
        @(posedge clk);
        #1;
        chk("delay_a_rise", a, 1);
        chk("delay_busy", busy_o, 1);
        @(negedge clk);
        done_i = 1'b0;
        r      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("delay_a_fall", a, 0);
        chk("delay_count", count_o, 2);
        chk("delay_err", err_o, 0);

        // done_i in IDLE is a protocol error.
        @(negedge clk);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        chk("idle_done_err", err_o, 1);
        chk("idle_done_a", a, 0);

        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst2_err", err_o, 0);
        chk("rst2_count", count_o, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Request withdrawn during WAIT_DONE.
        @(negedge clk);
        r = 1'b1;
        wait_lvl(0, 1'b1, "wd_start");
        r = 1'b0;
        repeat (4) @(negedge clk);
        chk("wd_err", err_o, 1);
        chk("wd_busy", busy_o, 1);
        chk("wd_a_low", a, 0);
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        chk("wd_a_rise", a, 1);
        @(negedge clk);
        chk("wd_a_fall", a, 0);
        chk("wd_count", count_o, 1);

        // Mid-handshake reset: a drops at once, then a clean handshake.
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        handshake(0, 2, 1'b0);
        chk("mid_a_high", a, 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_a", a, 0);
        chk("mid_rst_count", count_o, 0);
        r = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        handshake(3, 1, 1'b1);
        chk("mid_after_count", count_o, 1);
        chk("mid_after_err", err_o, 0);

        // Back-to-back traffic with varied service delay and hold time.
        for (int n = 0; n < 10; n++) begin
            handshake(n % 4, (n % 2) ? 3 : 1, 1'b1);
        end
        chk("b2b_count", count_o, 11);
        chk("b2b_err", err_o, 0);
        chk("b2b_start_while_busy", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_slave_4ph

`default_nettype wire
